// File: rtl/pes_graycode_sched_if.sv
// Bus between the gray-counter scheduler and its environment (requesters + shared counter).
interface pes_graycode_sched_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 8
);
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [WIDTH-1:0] gray_count;
    logic             err_clr;
    logic             gc_enable;
    logic [1:0]       grant;
    logic [1:0]       done;
    logic             busy;
    logic [WIDTH-1:0] gray_last;
    logic             err;

    // Environment side: requesters, counter output and error clear
    modport master (
        output req, len0, len1, gray_count, err_clr,
        input  gc_enable, grant, done, busy, gray_last, err
    );

    // Scheduler side
    modport slave (
        input  req, len0, len1, gray_count, err_clr,
        output gc_enable, grant, done, busy, gray_last, err
    );
endinterface

// File: rtl/pes_graycode_sched.sv
// Round-robin scheduler granting a shared gray counter to two requesters for
// fixed-length bursts, with a checker flagging illegal gray-count transitions.
module pes_graycode_sched #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    pes_graycode_sched_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state,     w_state_nxt;
    logic             r_owner,     w_owner_nxt;
    logic             r_ptr,       w_ptr_nxt;
    logic [LEN_W-1:0] r_remaining, w_remaining_nxt;
    logic             w_winner;

    logic [1:0]       r_grant,     w_grant_nxt;
    logic [1:0]       r_done,      w_done_nxt;
    logic             r_gc_enable, w_gc_enable_nxt;
    logic             r_busy,      w_busy_nxt;
    logic [WIDTH-1:0] r_gray_last;

    logic [WIDTH-1:0] r_gray_prev;
    logic             r_en_prev;
    logic             r_chk_valid;
    logic             r_err;
    logic [WIDTH-1:0] w_diff;
    logic             w_violation;

    // Arbitration: lone requester wins, otherwise the priority pointer decides
    always_comb begin
        w_winner = r_ptr;
        if (bus.req == 2'b01) begin
            w_winner = 1'b0;
        end else if (bus.req == 2'b10) begin
            w_winner = 1'b1;
        end
    end

    // Next-state, bookkeeping and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_ptr_nxt       = r_ptr;
        w_remaining_nxt = r_remaining;
        case (r_state)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    w_state_nxt     = S_GRANT;
                    w_owner_nxt     = w_winner;
                    w_remaining_nxt = w_winner ? bus.len1 : bus.len0;
                end
            end
            S_GRANT: begin
                if (r_remaining == '0) begin
                    w_state_nxt = S_DONE;
                    w_ptr_nxt   = ~r_owner;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_remaining_nxt = r_remaining - LEN_W'(1);
                if (r_remaining == LEN_W'(1)) begin
                    w_state_nxt = S_DONE;
                    w_ptr_nxt   = ~r_owner;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_grant_nxt     = 2'b00;
        w_done_nxt      = 2'b00;
        w_gc_enable_nxt = (w_state_nxt == S_RUN);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        if (w_state_nxt != S_IDLE) begin
            w_grant_nxt = w_owner_nxt ? 2'b10 : 2'b01;
        end
        if (w_state_nxt == S_DONE) begin
            w_done_nxt = w_owner_nxt ? 2'b10 : 2'b01;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_ptr       <= 1'b0;
            r_remaining <= '0;
            r_grant     <= 2'b00;
            r_done      <= 2'b00;
            r_gc_enable <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_ptr       <= w_ptr_nxt;
            r_remaining <= w_remaining_nxt;
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
            r_gc_enable <= w_gc_enable_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Capture the counter value as the DONE cycle ends
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gray_last <= '0;
        end else if (r_state == S_DONE) begin
            r_gray_last <= bus.gray_count;
        end
    end

    // Gray-sequence legality: one bit flip per enabled step, no change otherwise
    always_comb begin
        w_diff      = bus.gray_count ^ r_gray_prev;
        w_violation = 1'b0;
        if (r_chk_valid) begin
            if (r_en_prev) begin
                w_violation = ($countones(w_diff) != 1);
            end else begin
                w_violation = (w_diff != '0);
            end
        end
    end

    // Checker history and sticky error; clear wins over a new violation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gray_prev <= '0;
            r_en_prev   <= 1'b0;
            r_chk_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_gray_prev <= bus.gray_count;
            r_en_prev   <= r_gc_enable;
            r_chk_valid <= 1'b1;
            if (bus.err_clr) begin
                r_err <= 1'b0;
            end else if (w_violation) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.gc_enable = r_gc_enable;
    assign bus.grant     = r_grant;
    assign bus.done      = r_done;
    assign bus.busy      = r_busy;
    assign bus.gray_last = r_gray_last;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_pes_graycode_sched.sv
// Directed bench for pes_graycode_sched with a behavioural shared gray counter.
module tb_pes_graycode_sched;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] r_bin;
    logic [7:0] r_inj;
    int         vectors = 0;
    int         miscompares = 0;

    int         cyc;
    int         n_en;
    logic [1:0] g;
    logic [1:0] d;

    always #5 clk = ~clk;

    pes_graycode_sched_if #(.WIDTH(8), .LEN_W(8)) bus ();

    pes_graycode_sched #(.WIDTH(8), .LEN_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Shared binary counter presented in gray code; r_inj corrupts it on demand
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bin <= 8'd0;
        end else if (bus.gc_enable) begin
            r_bin <= r_bin + 8'd1;
        end
    end
    assign bus.gray_count = (r_bin ^ (r_bin >> 1)) ^ r_inj;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset       = 1'b0;
        bus.req     = 2'b00;
        bus.len0    = 8'd0;
        bus.len1    = 8'd0;
        bus.err_clr = 1'b0;
        r_inj       = 8'h00;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Step until a done pulse (bounded); report cycles, enables, first grant, done
    task automatic wait_done(output int c, output int n, output logic [1:0] gg, output logic [1:0] dd);
        c  = 0;
        n  = 0;
        gg = 2'b00;
        dd = 2'b00;
        while (dd == 2'b00 && c < 600) begin
            tick();
            c++;
            if (bus.gc_enable) n++;
            if (gg == 2'b00) gg = bus.grant;
            dd = bus.done;
        end
    endtask

    initial begin
        // Reset state
        reset       = 1'b0;
        bus.req     = 2'b00;
        bus.len0    = 8'd0;
        bus.len1    = 8'd0;
        bus.err_clr = 1'b0;
        r_inj       = 8'h00;
        #1;
        check_eq("rst_grant", 32'(bus.grant), 32'h0);
        check_eq("rst_gc_en", 32'(bus.gc_enable), 32'h0);
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        check_eq("rst_done", 32'(bus.done), 32'h0);
        check_eq("rst_glast", 32'(bus.gray_last), 32'h0);
        check_eq("rst_err", 32'(bus.err), 32'h0);

        // Single burst, requester 0, length 5
        do_reset();
        bus.req  = 2'b01;
        bus.len0 = 8'd5;
        wait_done(cyc, n_en, g, d);
        bus.req = 2'b00;
        check_eq("b5_cycles", 32'(cyc), 32'd7);
        check_eq("b5_enables", 32'(n_en), 32'd5);
        check_eq("b5_grant", 32'(g), 32'h1);
        check_eq("b5_done", 32'(d), 32'h1);
        check_eq("b5_gc_en_in_done", 32'(bus.gc_enable), 32'h0);
        tick();
        check_eq("b5_glast", 32'(bus.gray_last), 32'h07);
        check_eq("b5_idle_grant", 32'(bus.grant), 32'h0);
        check_eq("b5_idle_busy", 32'(bus.busy), 32'h0);
        check_eq("b5_idle_done", 32'(bus.done), 32'h0);
        check_eq("b5_err", 32'(bus.err), 32'h0);

        // Both requesting: 0 first, then 1, then 0 again; req dropped mid-burst
        do_reset();
        bus.req  = 2'b11;
        bus.len0 = 8'd3;
        bus.len1 = 8'd2;
        wait_done(cyc, n_en, g, d);
        check_eq("rr1_cycles", 32'(cyc), 32'd5);
        check_eq("rr1_enables", 32'(n_en), 32'd3);
        check_eq("rr1_grant", 32'(g), 32'h1);
        check_eq("rr1_done", 32'(d), 32'h1);
        tick();
        check_eq("rr1_gap_grant", 32'(bus.grant), 32'h0);
        check_eq("rr1_gap_busy", 32'(bus.busy), 32'h0);
        check_eq("rr1_glast", 32'(bus.gray_last), 32'h02);
        wait_done(cyc, n_en, g, d);
        check_eq("rr2_cycles", 32'(cyc), 32'd4);
        check_eq("rr2_enables", 32'(n_en), 32'd2);
        check_eq("rr2_grant", 32'(g), 32'h2);
        check_eq("rr2_done", 32'(d), 32'h2);
        tick();
        check_eq("rr2_glast", 32'(bus.gray_last), 32'h07);
        tick();
        check_eq("rr3_grant", 32'(bus.grant), 32'h1);
        bus.req = 2'b00;
        wait_done(cyc, n_en, g, d);
        check_eq("rr3_cycles", 32'(cyc), 32'd4);
        check_eq("rr3_enables", 32'(n_en), 32'd3);
        check_eq("rr3_grant", 32'(g), 32'h1);
        check_eq("rr3_done", 32'(d), 32'h1);
        tick();
        check_eq("rr3_glast", 32'(bus.gray_last), 32'h0C);
        tick();
        check_eq("rr3_stay_idle", 32'(bus.busy), 32'h0);
        check_eq("rr_err", 32'(bus.err), 32'h0);

        // Zero-length burst for requester 1
        do_reset();
        bus.req  = 2'b10;
        bus.len1 = 8'd0;
        wait_done(cyc, n_en, g, d);
        bus.req = 2'b00;
        check_eq("z_cycles", 32'(cyc), 32'd2);
        check_eq("z_enables", 32'(n_en), 32'd0);
        check_eq("z_grant", 32'(g), 32'h2);
        check_eq("z_done", 32'(d), 32'h2);
        check_eq("z_count", 32'(bus.gray_count), 32'h00);
        tick();
        check_eq("z_glast", 32'(bus.gray_last), 32'h00);
        check_eq("z_err", 32'(bus.err), 32'h0);

        // Maximum length, then a short burst wrapping the counter
        do_reset();
        bus.req  = 2'b01;
        bus.len0 = 8'd255;
        wait_done(cyc, n_en, g, d);
        check_eq("max_cycles", 32'(cyc), 32'd257);
        check_eq("max_enables", 32'(n_en), 32'd255);
        check_eq("max_done", 32'(d), 32'h1);
        bus.len0 = 8'd2;
        tick();
        check_eq("max_glast", 32'(bus.gray_last), 32'h80);
        wait_done(cyc, n_en, g, d);
        bus.req = 2'b00;
        check_eq("wrap_cycles", 32'(cyc), 32'd4);
        check_eq("wrap_enables", 32'(n_en), 32'd2);
        tick();
        check_eq("wrap_glast", 32'(bus.gray_last), 32'h01);
        check_eq("wrap_err", 32'(bus.err), 32'h0);

        // Checker: multi-bit jump during RUN, change while idle, clear priority
        do_reset();
        bus.req  = 2'b01;
        bus.len0 = 8'd6;
        tick();
        tick();
        tick();
        check_eq("chk_err_pre", 32'(bus.err), 32'h0);
        r_inj = 8'h30;
        tick();
        check_eq("chk_err_jump", 32'(bus.err), 32'h1);
        r_inj = 8'h00;
        tick();
        check_eq("chk_err_hold", 32'(bus.err), 32'h1);
        wait_done(cyc, n_en, g, d);
        bus.req = 2'b00;
        check_eq("chk_done", 32'(d), 32'h1);
        tick();
        tick();
        check_eq("chk_err_sticky", 32'(bus.err), 32'h1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check_eq("chk_err_clr", 32'(bus.err), 32'h0);
        tick();
        check_eq("chk_err_quiet", 32'(bus.err), 32'h0);
        r_inj = 8'h01;
        tick();
        check_eq("chk_err_idle_chg", 32'(bus.err), 32'h1);
        tick();
        check_eq("chk_err_idle_hold", 32'(bus.err), 32'h1);
        r_inj       = 8'h00;
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check_eq("chk_clr_priority", 32'(bus.err), 32'h0);
        tick();
        check_eq("chk_err_after", 32'(bus.err), 32'h0);

        // Reset during the third RUN cycle, then restart with req held
        do_reset();
        bus.req  = 2'b01;
        bus.len0 = 8'd10;
        tick();
        tick();
        tick();
        tick();
        check_eq("ar_running", 32'(bus.gc_enable), 32'h1);
        reset = 1'b0;
        #1;
        check_eq("ar_gc_en", 32'(bus.gc_enable), 32'h0);
        check_eq("ar_grant", 32'(bus.grant), 32'h0);
        check_eq("ar_busy", 32'(bus.busy), 32'h0);
        check_eq("ar_done", 32'(bus.done), 32'h0);
        tick();
        check_eq("ar_no_done", 32'(bus.done), 32'h0);
        reset = 1'b1;
        tick();
        check_eq("ar_regrant", 32'(bus.grant), 32'h1);
        wait_done(cyc, n_en, g, d);
        bus.req = 2'b00;
        check_eq("ar_enables", 32'(n_en), 32'd10);
        check_eq("ar_done_pulse", 32'(d), 32'h1);
        tick();
        check_eq("ar_glast", 32'(bus.gray_last), 32'h0F);
        check_eq("ar_err", 32'(bus.err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
